mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports are listed below, clock and reset first.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 ALUResultIn  in  32  effective address, or the ALU result for non-memory ops.
REQ-005 MemDataIn  in  32  store data.
REQ-006 MultResultIn  in  64  multiplier product.
REQ-007 rdRegIn  in  5  destination register.
REQ-008 RegWriteIn, MemReadIn, MemWriteIn, MemToRegIn, HiLoWriteIn  in  1 each  control bits from the EX/MEM register.
REQ-009 dataTypeIn  in  2  access size: 00 word, 01 half, 10 byte, 11 treated as word.
REQ-010 MemAddr  out  32  word-aligned address, {ALUResultIn[31:2],2'b00}.
REQ-011 MemWData  out  32  store data, lane-replicated; MemBE out 4 byte enables; MemReq out 1; MemWe out 1.
REQ-012 MemAck  in  1 and MemRData  in  32  memory completion and read data.
REQ-013 Stall  out  1  upstream stages hold while high.
REQ-014 WBDataOut  out  32; rdRegOut  out  5; RegWriteOut  out  1; HiOut, LoOut  out  32 each.
REQ-015 AlignErrOut, BusErrOut  out  1 each  one-cycle error pulses.

Function
REQ-016 FSM SHALL have the states IDLE, REQ and DONE.
REQ-017 memop SHALL be defined as MemReadIn|MemWriteIn; aligned SHALL be true for word accesses with addr[1:0]=00, half accesses with addr[0]=0, and any byte access.
REQ-018 IDLE: memop&aligned -> REQ; otherwise stay in IDLE.
REQ-019 REQ: MemReq=1 and MemWe=MemWriteIn; MemAck -> DONE, capturing MemRData; 16 consecutive REQ cycles without MemAck -> DONE with the bus-error flag set.
REQ-020 DONE SHALL go to IDLE unconditionally and SHALL NOT reissue the memory op, even though the inputs still present it.
REQ-021 Stall SHALL be combinational: (IDLE & memop & aligned) | REQ; Stall SHALL be 0 in DONE.
REQ-022 The WB registers (WBDataOut, rdRegOut, RegWriteOut) SHALL update on every edge where Stall=0; on edges where Stall=1 they SHALL load a bubble (RegWriteOut=0).
REQ-023 WBDataOut SHALL be the extracted load data when MemToRegIn=1, and ALUResultIn otherwise.
REQ-024 Load extraction SHALL be little-endian: byte = RData[8*addr[1:0]+:8], half = RData[16*addr[1]+:16]; byte and half loads SHALL be sign-extended to 32 bits.
REQ-025 Stores: byte SHALL use MemBE=1<<addr[1:0] with the data replicated x4; half SHALL use 0011 or 1100 by addr[1] with the data replicated x2; word SHALL use 1111.
REQ-026 Misaligned memop in IDLE: no MemReq, no stall, RegWriteOut=0 registered, AlignErrOut=1 for one cycle.
REQ-027 Bus error: RegWriteOut=0 and BusErrOut=1 for the one cycle following DONE.
REQ-028 HiLoWriteIn=1 on an edge with Stall=0 SHALL load HiOut<=MultResultIn[63:32] and LoOut<=MultResultIn[31:0].
REQ-029 Latency, non-memory op: WB outputs SHALL be valid one cycle after the op is presented.
REQ-030 Latency, memory op: WB outputs SHALL be valid 1 cycle after DONE; minimum is 3 cycles from presentation, with Stall high for 2 cycles.
REQ-031 The timeout counter SHALL be 4 bits, clear on entry to REQ and be held in the other states.
REQ-032 A MemAck arriving outside REQ SHALL be ignored.

Reset
REQ-033 rst_n=0 SHALL immediately force: state IDLE; MemReq, MemWe, MemBE and Stall to 0; WBDataOut, rdRegOut, RegWriteOut, HiOut and LoOut to 0; error pulses to 0; counter to 0.
REQ-034 Reset asserted during REQ SHALL drop MemReq within the same cycle, and any pending transfer SHALL be abandoned.
REQ-035 After rst_n deasserts, the first rising edge SHALL behave as from IDLE.

Verification
REQ-036 Word load: addr 0x100, MemRData=0xDEADBEEF, MemAck on the 1st REQ cycle -> Stall high for 2 cycles, then WBDataOut=0xDEADBEEF with RegWriteOut=1.
REQ-037 Byte load: addr 0x103, MemRData=0x80112233 -> WBDataOut=0xFFFFFF80; half load at 0x102 -> WBDataOut=0xFFFF8011.
REQ-038 Half store 0x0000ABCD at addr 0x202 -> MemBE=1100, MemWData=0xABCDABCD, MemWe=1, RegWriteOut=0.
REQ-039 Word load at addr 0x101 -> MemReq never asserts, AlignErrOut pulses once, RegWriteOut=0.
REQ-040 MemAck withheld for 16 REQ cycles -> DONE, BusErrOut=1 for one cycle, Stall released, no register write.
REQ-041 HiLoWriteIn=1 with MultResultIn=0x00000001_FFFFFFFE -> HiOut=1 and LoOut=0xFFFFFFFE; rst_n pulsed mid-REQ -> MemReq=0 and all outputs 0 asynchronously.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Memory bus between the access unit and its data memory.
//   MemAddr  : word-aligned request address
//   MemWData : lane-replicated store data
//   MemBE    : byte enables (little-endian lanes)
//   MemReq   : request valid, held until MemAck or timeout
//   MemWe    : 1 = store, 0 = load
//   MemAck   : completion strobe from memory
//   MemRData : read data, valid with MemAck
interface mem_access_unit_if;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [3:0]  MemBE;
  logic        MemReq;
  logic        MemWe;
  logic        MemAck;
  logic [31:0] MemRData;

  modport master (
    output MemAddr, MemWData, MemBE, MemReq, MemWe,
    input  MemAck, MemRData
  );

  modport slave (
    input  MemAddr, MemWData, MemBE, MemReq, MemWe,
    output MemAck, MemRData
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues loads/stores to a handshaked memory,
// stalls upstream while a transfer is in flight, formats load data and
// registers the write-back results plus the HI/LO multiplier outputs.
//   clk, rst_n           : clock, asynchronous active-low reset
//   ALUResultIn          : effective address or plain ALU result
//   MemDataIn            : store data
//   MultResultIn         : 64-bit product for HI/LO
//   rdRegIn, *In controls: EX/MEM control bits
//   dataTypeIn           : 00 word, 01 half, 10 byte, 11 word
//   mem                  : memory bus (master side)
//   Stall                : hold upstream stages
//   WBDataOut, rdRegOut, RegWriteOut : write-back register
//   HiOut, LoOut         : multiplier result registers
//   AlignErrOut, BusErrOut : one-cycle error pulses
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] MemDataIn,
  input  logic [63:0] MultResultIn,
  input  logic [4:0]  rdRegIn,
  input  logic        RegWriteIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic        MemToRegIn,
  input  logic        HiLoWriteIn,
  input  logic [1:0]  dataTypeIn,
  mem_access_unit_if.master mem,
  output logic        Stall,
  output logic [31:0] WBDataOut,
  output logic [4:0]  rdRegOut,
  output logic        RegWriteOut,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut,
  output logic        AlignErrOut,
  output logic        BusErrOut
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        berr_flag_q, berr_flag_d;

  logic [31:0] wb_data_q, hi_q, lo_q;
  logic [4:0]  rd_q;
  logic        reg_write_q, align_err_q, bus_err_q;

  logic        memop, aligned, misalign_idle, start;
  logic        is_byte, is_half;
  logic [1:0]  a_lo;
  logic [3:0]  be_sel;
  logic [31:0] wdata_sel, load_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign a_lo    = ALUResultIn[1:0];
  assign is_byte = (dataTypeIn == 2'b10);
  assign is_half = (dataTypeIn == 2'b01);
  assign memop   = MemReadIn | MemWriteIn;
  assign aligned = is_byte | (is_half & ~a_lo[0]) | (~is_byte & ~is_half & (a_lo == 2'b00));

  assign start         = (state_q == IDLE) & memop & aligned;
  assign misalign_idle = (state_q == IDLE) & memop & ~aligned;

  // Gated by rst_n so Stall drops immediately when reset asserts, even
  // while a memory op is still presented on the inputs.
  assign Stall = rst_n & (start | (state_q == REQ));

  // Store lane steering
  always_comb begin
    be_sel    = 4'b1111;
    wdata_sel = MemDataIn;
    if (is_byte) begin
      be_sel    = 4'b0001 << a_lo;
      wdata_sel = {4{MemDataIn[7:0]}};
    end else if (is_half) begin
      be_sel    = a_lo[1] ? 4'b1100 : 4'b0011;
      wdata_sel = {2{MemDataIn[15:0]}};
    end
  end

  // Little-endian load extraction with sign extension
  always_comb begin
    ld_byte   = rdata_q[8*a_lo +: 8];
    ld_half   = rdata_q[16*a_lo[1] +: 16];
    load_data = rdata_q;
    if (is_byte)
      load_data = {{24{ld_byte[7]}}, ld_byte};
    else if (is_half)
      load_data = {{16{ld_half[15]}}, ld_half};
  end

  assign mem.MemAddr  = {ALUResultIn[31:2], 2'b00};
  assign mem.MemWData = wdata_sel;
  assign mem.MemReq   = (state_q == REQ);
  assign mem.MemWe    = (state_q == REQ) & MemWriteIn;
  assign mem.MemBE    = (state_q == REQ) ? be_sel : 4'b0000;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    berr_flag_d = berr_flag_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = REQ;
          cnt_d       = 4'd0;
          berr_flag_d = 1'b0;
        end
      end
      REQ: begin
        if (mem.MemAck) begin
          state_d = DONE;
          rdata_d = mem.MemRData;
        end else if (cnt_q == 4'hF) begin
          // 16th consecutive REQ cycle without acknowledge
          state_d     = DONE;
          berr_flag_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rdata_q     <= 32'd0;
      berr_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      berr_flag_q <= berr_flag_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data_q   <= 32'd0;
      rd_q        <= 5'd0;
      reg_write_q <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      align_err_q <= misalign_idle;
      bus_err_q   <= (state_q == DONE) & berr_flag_q;
      if (Stall) begin
        reg_write_q <= 1'b0;
      end else begin
        wb_data_q   <= MemToRegIn ? load_data : ALUResultIn;
        rd_q        <= rdRegIn;
        reg_write_q <= RegWriteIn & ~misalign_idle & ~((state_q == DONE) & berr_flag_q);
        if (HiLoWriteIn) begin
          hi_q <= MultResultIn[63:32];
          lo_q <= MultResultIn[31:0];
        end
      end
    end
  end

  assign WBDataOut   = wb_data_q;
  assign rdRegOut    = rd_q;
  assign RegWriteOut = reg_write_q;
  assign HiOut       = hi_q;
  assign LoOut       = lo_q;
  assign AlignErrOut = align_err_q;
  assign BusErrOut   = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ALUResultIn = '0;
  logic [31:0] MemDataIn = '0;
  logic [63:0] MultResultIn = '0;
  logic [4:0]  rdRegIn = '0;
  logic        RegWriteIn = 0, MemReadIn = 0, MemWriteIn = 0, MemToRegIn = 0, HiLoWriteIn = 0;
  logic [1:0]  dataTypeIn = '0;
  logic        Stall, RegWriteOut, AlignErrOut, BusErrOut;
  logic [31:0] WBDataOut, HiOut, LoOut;
  logic [4:0]  rdRegOut;

  mem_access_unit_if mem_bus ();

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .ALUResultIn(ALUResultIn), .MemDataIn(MemDataIn), .MultResultIn(MultResultIn),
    .rdRegIn(rdRegIn), .RegWriteIn(RegWriteIn), .MemReadIn(MemReadIn),
    .MemWriteIn(MemWriteIn), .MemToRegIn(MemToRegIn), .HiLoWriteIn(HiLoWriteIn),
    .dataTypeIn(dataTypeIn), .mem(mem_bus.master), .Stall(Stall),
    .WBDataOut(WBDataOut), .rdRegOut(rdRegOut), .RegWriteOut(RegWriteOut),
    .HiOut(HiOut), .LoOut(LoOut), .AlignErrOut(AlignErrOut), .BusErrOut(BusErrOut)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        rw;
    logic        aerr;
    logic        berr;
    int          stalls;
    int          reqs;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_hi = 0, exp_lo = 0;

  initial begin
    mem_bus.MemAck   = 1'b0;
    mem_bus.MemRData = 32'd0;
  end

  task automatic set_nop();
    MemReadIn = 0; MemWriteIn = 0; MemToRegIn = 0; RegWriteIn = 0; HiLoWriteIn = 0;
    ALUResultIn = 0; MemDataIn = 0; dataTypeIn = 0; rdRegIn = 0; MultResultIn = 0;
  endtask

  // Presents one op, services memory, then pops and checks its expectation.
  // ack_delay: REQ cycles before acknowledge (16 = never acknowledge).
  task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                       input logic m2r, input logic hl, input logic [63:0] mult,
                       input logic [1:0] dt, input logic [31:0] rdata,
                       input int ack_delay, input bit ack_early);
    exp_t e;
    logic [31:0] sh;
    logic aligned, memop;
    int n, stall_cnt, req_cnt;
    bit done;
    ALUResultIn = a; MemDataIn = d; rdRegIn = rd; RegWriteIn = rw; MemReadIn = mr;
    MemWriteIn = mw; MemToRegIn = m2r; HiLoWriteIn = hl; MultResultIn = mult; dataTypeIn = dt;

    // Independent expectation model
    memop = mr | mw;
    aligned = (dt == 2'b10) ? 1'b1 : (dt == 2'b01) ? (a[0] == 1'b0) : (a[1:0] == 2'b00);
    e.addr = a & 32'hFFFF_FFFC;
    e.we = mw;
    if (dt == 2'b10) begin
      e.be = 4'(1 << a[1:0]); e.wdata = {24'd0, d[7:0]} * 32'h0101_0101;
    end else if (dt == 2'b01) begin
      e.be = a[1] ? 4'b1100 : 4'b0011; e.wdata = {16'd0, d[15:0]} * 32'h0001_0001;
    end else begin
      e.be = 4'b1111; e.wdata = d;
    end
    sh = rdata >> (8 * a[1:0]);
    if (dt == 2'b10)      e.wb = sh[7] ? (sh | 32'hFFFF_FF00) & 32'hFFFF_FFFF : sh & 32'hFF;
    else if (dt == 2'b01) e.wb = sh[15] ? (sh | 32'hFFFF_0000) : sh & 32'hFFFF;
    else                  e.wb = rdata;
    if (!m2r) e.wb = a;
    e.rd = rd; e.aerr = 0; e.berr = 0; e.stalls = 0; e.reqs = 0; e.rw = rw;
    if (memop && aligned) begin
      e.berr = (ack_delay >= 16);
      e.reqs = e.berr ? 16 : ack_delay + 1;
      e.stalls = e.reqs + 1;
      e.rw = rw & ~e.berr;
    end else if (memop) begin
      e.aerr = 1; e.rw = 0;
    end
    if (hl) begin exp_hi = mult[63:32]; exp_lo = mult[31:0]; end
    sb.push_back(e);

    n = 0; stall_cnt = 0; req_cnt = 0; done = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      if (mem_bus.MemReq) begin
        req_cnt++;
        if (req_cnt == 1) begin
          checks++;
          if (mem_bus.MemAddr !== e.addr || mem_bus.MemBE !== e.be ||
              mem_bus.MemWData !== e.wdata || mem_bus.MemWe !== e.we) begin
            failures++;
            $display("FAIL %s bus: addr=%h be=%b wdata=%h we=%b required addr=%h be=%b wdata=%h we=%b",
                     nm, mem_bus.MemAddr, mem_bus.MemBE, mem_bus.MemWData, mem_bus.MemWe,
                     e.addr, e.be, e.wdata, e.we);
          end
        end
        if (ack_delay == req_cnt - 1) begin
          mem_bus.MemAck = 1'b1; mem_bus.MemRData = rdata;
        end
      end else if (ack_early && Stall) begin
        mem_bus.MemAck = 1'b1; mem_bus.MemRData = 32'h5555_5555;
      end
      if (Stall) stall_cnt++; else done = 1;
      @(posedge clk); #1;
      mem_bus.MemAck = 1'b0; mem_bus.MemRData = 32'd0;
      n++;
    end

    e = sb.pop_front();
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s timeout: stall still high after %0d cycles, required release", nm, n);
    end
    checks++;
    if (stall_cnt != e.stalls || req_cnt != e.reqs) begin
      failures++;
      $display("FAIL %s timing: stalls=%0d reqs=%0d required stalls=%0d reqs=%0d",
               nm, stall_cnt, req_cnt, e.stalls, e.reqs);
    end
    checks++;
    if (RegWriteOut !== e.rw || AlignErrOut !== e.aerr || BusErrOut !== e.berr) begin
      failures++;
      $display("FAIL %s flags: rw=%b aerr=%b berr=%b required rw=%b aerr=%b berr=%b",
               nm, RegWriteOut, AlignErrOut, BusErrOut, e.rw, e.aerr, e.berr);
    end
    if (e.rw) begin
      checks++;
      if (WBDataOut !== e.wb || rdRegOut !== e.rd) begin
        failures++;
        $display("FAIL %s wb: data=%h rd=%0d required data=%h rd=%0d", nm, WBDataOut, rdRegOut, e.wb, e.rd);
      end
    end
    checks++;
    if (HiOut !== exp_hi || LoOut !== exp_lo) begin
      failures++;
      $display("FAIL %s hilo: hi=%h lo=%h required hi=%h lo=%h", nm, HiOut, LoOut, exp_hi, exp_lo);
    end
    $display("op %-12s addr=%h wb=%h rw=%b stalls=%0d reqs=%0d aerr=%b berr=%b",
             nm, a, WBDataOut, RegWriteOut, stall_cnt, req_cnt, AlignErrOut, BusErrOut);
    set_nop();
  endtask

  task automatic check_quiet(input string nm);
    @(posedge clk); #1;
    checks++;
    if (AlignErrOut !== 1'b0 || BusErrOut !== 1'b0 || Stall !== 1'b0 || mem_bus.MemReq !== 1'b0) begin
      failures++;
      $display("FAIL %s quiet: aerr=%b berr=%b stall=%b req=%b required all 0",
               nm, AlignErrOut, BusErrOut, Stall, mem_bus.MemReq);
    end
  endtask

  task automatic test_reset();
    set_nop();
    MemReadIn = 1; // memop presented during reset must not stall
    #1;
    checks++;
    if (Stall !== 0 || mem_bus.MemReq !== 0 || mem_bus.MemWe !== 0 || mem_bus.MemBE !== 0 ||
        WBDataOut !== 0 || rdRegOut !== 0 || RegWriteOut !== 0 || HiOut !== 0 || LoOut !== 0 ||
        AlignErrOut !== 0 || BusErrOut !== 0) begin
      failures++;
      $display("FAIL reset: stall=%b req=%b be=%b wb=%h rw=%b hi=%h lo=%h required all 0",
               Stall, mem_bus.MemReq, mem_bus.MemBE, WBDataOut, RegWriteOut, HiOut, LoOut);
    end
    set_nop();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    do_op("word_load", 32'h100, 0, 5'd3, 1, 1, 0, 1, 0, 0, 2'b00, 32'hDEAD_BEEF, 0, 0);
    do_op("byte_load", 32'h103, 0, 5'd4, 1, 1, 0, 1, 0, 0, 2'b10, 32'h8011_2233, 0, 0);
    do_op("half_load", 32'h102, 0, 5'd5, 1, 1, 0, 1, 0, 0, 2'b01, 32'h8011_2233, 1, 0);
    do_op("byte_load1", 32'h101, 0, 5'd6, 1, 1, 0, 1, 0, 0, 2'b10, 32'h8011_2233, 3, 0);
    do_op("half_load0", 32'h200, 0, 5'd7, 1, 1, 0, 1, 0, 0, 2'b01, 32'h1234_7FFE, 0, 0);
    do_op("type11_load", 32'h104, 0, 5'd8, 1, 1, 0, 1, 0, 0, 2'b11, 32'hCAFE_F00D, 2, 0);
  endtask

  task automatic test_stores();
    do_op("half_store", 32'h202, 32'h0000_ABCD, 5'd0, 0, 0, 1, 0, 0, 0, 2'b01, 0, 0, 0);
    do_op("byte_store", 32'h201, 32'h0000_005A, 5'd0, 0, 0, 1, 0, 0, 0, 2'b10, 0, 1, 0);
    do_op("word_store", 32'h300, 32'h1357_9BDF, 5'd0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  task automatic test_misaligned();
    do_op("misalign_w", 32'h101, 0, 5'd9, 1, 1, 0, 1, 0, 0, 2'b00, 0, 0, 0);
    check_quiet("misalign_w");
    do_op("misalign_h", 32'h203, 32'h77, 5'd0, 0, 0, 1, 0, 0, 0, 2'b01, 0, 0, 0);
    check_quiet("misalign_h");
  endtask

  task automatic test_bus_error();
    do_op("bus_error", 32'h400, 0, 5'd10, 1, 1, 0, 1, 0, 0, 2'b00, 32'h1111_2222, 16, 0);
    check_quiet("bus_error");
    do_op("ack_last", 32'h404, 0, 5'd11, 1, 1, 0, 1, 0, 0, 2'b00, 32'h3333_4444, 15, 0);
  endtask

  task automatic test_ack_outside_req();
    do_op("early_ack", 32'h500, 0, 5'd12, 1, 1, 0, 1, 0, 0, 2'b00, 32'hA5A5_0F0F, 2, 1);
  endtask

  task automatic test_hilo();
    do_op("hilo", 32'h0, 0, 5'd0, 0, 0, 0, 0, 1, 64'h0000_0001_FFFF_FFFE, 2'b00, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] v;
      v = $urandom;
      do_op("alu_b2b", v, 0, 5'(i + 20), 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    end
    do_op("load_b2b", 32'h600, 0, 5'd30, 1, 1, 0, 1, 0, 0, 2'b00, 32'h0BAD_F00D, 0, 0);
    do_op("alu_after", 32'h1234_5678, 0, 5'd31, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  task automatic test_reset_mid_req();
    int n;
    ALUResultIn = 32'h700; MemReadIn = 1; MemToRegIn = 1; RegWriteIn = 1; rdRegIn = 5'd2;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_bus.MemReq && n < 5);
    checks++;
    if (!mem_bus.MemReq) begin
      failures++;
      $display("FAIL mid_req start: req=%b required 1", mem_bus.MemReq);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_bus.MemReq !== 0 || Stall !== 0 || mem_bus.MemBE !== 0 || WBDataOut !== 0 ||
        RegWriteOut !== 0 || rdRegOut !== 0 || HiOut !== 0 || LoOut !== 0) begin
      failures++;
      $display("FAIL mid_req reset: req=%b stall=%b be=%b wb=%h rw=%b hi=%h lo=%h required all 0",
               mem_bus.MemReq, Stall, mem_bus.MemBE, WBDataOut, RegWriteOut, HiOut, LoOut);
    end
    $display("reset mid-REQ: req=%b stall=%b hi=%h", mem_bus.MemReq, Stall, HiOut);
    set_nop();
    exp_hi = 0; exp_lo = 0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_quiet("after_reset");
    do_op("post_reset", 32'h704, 0, 5'd1, 1, 1, 0, 1, 0, 0, 2'b00, 32'h2468_ACE0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_bus_error();
    test_ack_outside_req();
    test_hilo();
    test_back_to_back();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
